// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the divide-by-zero result pattern.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MLA  = 2'b01,
    OP_UDIV = 2'b10,
    OP_SDIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // All-ones pattern wide enough for any supported WIDTH; users slice the low bits.
  localparam logic [63:0] DIV0_RESULT = '1;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for MUL/MLA, restoring subtract for divides.
// Purely combinational; the caller registers work/quotient between steps.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  op_t              op_i,
  input  logic [WIDTH-1:0] work_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [CNT_W-1:0] idx_i,
  output logic [WIDTH-1:0] work_o,
  output logic [WIDTH-1:0] quo_o
);

  localparam int IDX_W = $clog2(WIDTH);

  logic             is_div;
  logic [IDX_W-1:0] mul_idx;
  logic [IDX_W-1:0] div_idx;
  logic [WIDTH:0]   rem_sh;

  assign is_div  = (op_i == OP_UDIV) || (op_i == OP_SDIV);
  assign mul_idx = idx_i[IDX_W-1:0];
  // Divides walk the dividend from its MSB down while the counter counts up.
  assign div_idx = IDX_W'(WIDTH - 1) - mul_idx;
  assign rem_sh  = {work_i, a_i[div_idx]};

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    work_o = work_i;
    quo_o  = quo_i;
    if (!is_div) begin
      if (b_i[mul_idx]) work_o = work_i + (a_i << idx_i);
    end else if (rem_sh >= {1'b0, b_i}) begin
      work_o         = WIDTH'(rem_sh - {1'b0, b_i});
      quo_o[div_idx] = 1'b1;
    end else begin
      work_o = rem_sh[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MUL/MLA/UDIV unit, one radix-2 step per cycle, WIDTH cycles per op.
// Define MULDIV_SIGNED_DIV_EN to make op=11 a signed divide; otherwise it is UDIV.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;
`ifdef MULDIV_SIGNED_DIV_EN
  logic             neg_q, neg_d;
`endif

  logic [WIDTH-1:0] step_work;
  logic [WIDTH-1:0] step_quo;
  logic             op_is_div;

  muldiv_step #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step (
    .op_i   (op_q),
    .work_i (work_q),
    .quo_i  (quo_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .idx_i  (cnt_q),
    .work_o (step_work),
    .quo_o  (step_quo)
  );

  assign op_is_div = op[1];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    quo_d    = quo_q;
    result_d = result_q;
    dbz_d    = dbz_q;
`ifdef MULDIV_SIGNED_DIV_EN
    neg_d    = neg_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d   = op_t'(op);
          a_d    = a;
          b_d    = b;
          cnt_d  = '0;
          quo_d  = '0;
          work_d = (op_t'(op) == OP_MLA) ? acc : '0;
`ifdef MULDIV_SIGNED_DIV_EN
          neg_d  = 1'b0;
          if (op_t'(op) == OP_SDIV) begin
            a_d   = a[WIDTH-1] ? -a : a;
            b_d   = b[WIDTH-1] ? -b : b;
            neg_d = a[WIDTH-1] ^ b[WIDTH-1];
          end
`endif
          // A zero divisor short-circuits straight to DONE with the sentinel result.
          if (op_is_div && (b == '0)) begin
            state_d  = S_DONE;
            result_d = DIV0_RESULT[WIDTH-1:0];
            dbz_d    = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        work_d = step_work;
        quo_d  = step_quo;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          dbz_d   = 1'b0;
          if ((op_q == OP_UDIV) || (op_q == OP_SDIV)) begin
`ifdef MULDIV_SIGNED_DIV_EN
            result_d = neg_q ? -step_quo : step_quo;
`else
            result_d = step_quo;
`endif
          end else begin
            result_d = step_work;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      quo_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_DIV_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
`ifdef MULDIV_SIGNED_DIV_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares whenever done is high.
module tb_muldiv_seq;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] res;
    logic             dbz;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b, acc;
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] result;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  muldiv_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .acc         (acc),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: result 0x%0h with empty scoreboard", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, 64'(result), 64'(e.res));
        check({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
      end
    end
  end

  // Called just after a posedge; the next posedge is the accept edge.
  task automatic issue(input string name, input logic [1:0] o, input logic [WIDTH-1:0] va,
                       input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] vacc,
                       input logic [WIDTH-1:0] eres, input logic edbz);
    exp_t e;
    op    = o;
    a     = va;
    b     = vb;
    acc   = vacc;
    start = 1'b1;
    e.name = name;
    e.res  = eres;
    e.dbz  = edbz;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts negedges from the first cycle after accept until done; bounded.
  task automatic wait_done(input string name, output int lat, output int busy_cycles);
    lat         = 0;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cycles++;
      if (done) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s_timeout: no done within %0d cycles", name, lat);
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, bc;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    acc   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    realign();

    // MUL 7 x 6: busy for 32 cycles, done on cycle 33.
    issue("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);
    wait_done("mul_7x6", lat, bc);
    check("mul_latency", 64'(lat), 64'd33);
    check("mul_busy_cycles", 64'(bc), 64'd32);
    realign();
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    realign();

    issue("mla_wrap", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'h0000_0001, 1'b0);
    wait_done("mla_wrap", lat, bc);
    realign();

    issue("mul_wrap", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h1234_5678, 32'h0, 1'b0);
    wait_done("mul_wrap", lat, bc);
    realign();

    // UDIV 100/7 then a back-to-back issue during its DONE cycle.
    issue("udiv_100_7", 2'b10, 32'd100, 32'd7, 32'd0, 32'd14, 1'b0);
    wait_done("udiv_100_7", lat, bc);
    issue("udiv_ff_1", 2'b10, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);
    check("b2b_done_dropped", 64'(done), 64'd0);
    check("b2b_busy_rose", 64'(busy), 64'd1);
    wait_done("udiv_ff_1", lat, bc);
    check("b2b_latency", 64'(lat), 64'd33);
    realign();

    issue("udiv_small", 2'b10, 32'd7, 32'd100, 32'd0, 32'd0, 1'b0);
    wait_done("udiv_small", lat, bc);
    realign();

    // Divide by zero skips RUN entirely.
    issue("udiv_by0", 2'b10, 32'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1);
    wait_done("udiv_by0", lat, bc);
    check("div0_latency", 64'(lat), 64'd1);
    check("div0_busy_cycles", 64'(bc), 64'd0);
    realign();

    // A start pulse mid-RUN must not restart or re-sample operands.
    issue("mul_ignore_start", 2'b00, 32'd9, 32'd11, 32'd0, 32'd99, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    a     = 32'd1000;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("mul_ignore_start", lat, bc);
    check("ignore_start_latency", 64'(lat), 64'd27);
    realign();

    // Signed-divide option on op=11.
`ifdef MULDIV_SIGNED_DIV_EN
    issue("sdiv_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFD, 1'b0);
    wait_done("sdiv_m7_2", lat, bc);
    check("sdiv_latency", 64'(lat), 64'd33);
    realign();
    issue("sdiv_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    wait_done("sdiv_min_m1", lat, bc);
    realign();
`else
    issue("op3_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h7FFF_FFFC, 1'b0);
    wait_done("op3_m7_2", lat, bc);
    check("op3_latency", 64'(lat), 64'd33);
    realign();
`endif
    issue("op3_by0", 2'b11, 32'd12, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1);
    wait_done("op3_by0", lat, bc);
    realign();

    // Reset during RUN cycle 10: outputs clear immediately, pending result dropped.
    issue("mul_aborted", 2'b00, 32'd123, 32'd456, 32'd0, 32'd56088, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("pre_abort_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_dbz", 64'(div_by_zero), 64'd0);
    void'(sb.pop_back());
    realign();
    reset = 1'b0;
    issue("mul_after_reset", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    wait_done("mul_after_reset", lat, bc);
    check("post_reset_latency", 64'(lat), 64'd33);
    realign();
    repeat (2) @(posedge clk);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
